evt2_word_assembler: RTL and testbench

Byte-to-word front end between `uart_rx` and `voxel_bin_core`. It assembles MSB-first UART bytes into 32-bit EVT2.0 words and separates out the control bytes 0xFC–0xFF. Words are delivered through a 2-entry output buffer with a valid/ready handshake. Overflow drops are counted, and an inter-byte timeout resynchronises after lost bytes, so a dropped byte cannot misalign every following word.

---
 rtl/evt2_word_assembler.sv | 181 ++++++++++++++++++
 tb/tb_evt2_word_assembler.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/evt2_word_assembler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : evt2_word_assembler
// Purpose : Packs MSB-first UART bytes into 32-bit EVT2 words behind a
//           2-entry valid/ready buffer; control bytes 0xFC-0xFF are split off.
//           Optional inter-byte timeout resync: define EVT2_ASM_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module evt2_word_assembler #(
  parameter int CLK_FREQ      = 12_000_000,
  parameter int BAUD_RATE     = 115200,
  parameter int TIMEOUT_BYTES = 4,
  parameter int DROP_CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [31:0]           evt_word,
  output logic                  evt_word_valid,
  input  logic                  evt_word_ready,
  output logic [7:0]            cmd_byte,
  output logic                  cmd_valid,
  output logic [DROP_CNT_W-1:0] drop_count,
  output logic                  sync_error,
  output logic [1:0]            asm_state
);

  localparam int TIMEOUT_CYCLES = TIMEOUT_BYTES * 10 * (CLK_FREQ / BAUD_RATE);

  typedef enum logic [1:0] {
    B0 = 2'd0,
    B1 = 2'd1,
    B2 = 2'd2,
    B3 = 2'd3
  } asm_state_t;

  asm_state_t            state_q, state_d;
  logic [23:0]           partial_q, partial_d;
  logic [31:0]           ent0_q, ent0_d;
  logic [31:0]           ent1_q, ent1_d;
  logic [1:0]            occ_q, occ_d;
  logic [7:0]            cmd_byte_q, cmd_byte_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic                  sync_error_q, sync_error_d;

  logic                  timeout;
  logic                  push;
  logic                  pop;
  logic                  accept;
  logic [1:0]            occ_popped;
  logic [31:0]           new_word;

`ifdef EVT2_ASM_TIMEOUT_EN
  localparam int              GAP_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

  logic [GAP_W-1:0] gap_q, gap_d;

  // A byte arriving in the expiry cycle clears the counter first, so it wins.
  always_comb begin
    gap_d   = gap_q;
    timeout = 1'b0;
    if (rx_valid || (state_q == B0)) begin
      gap_d = '0;
    end else if (gap_q == GAP_LAST) begin
      gap_d   = '0;
      timeout = 1'b1;
    end else begin
      gap_d = gap_q + GAP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout            = 1'b0;
`endif

  // Assembler FSM and command capture
  always_comb begin
    state_d      = state_q;
    partial_d    = partial_q;
    cmd_byte_d   = cmd_byte_q;
    cmd_valid_d  = 1'b0;
    sync_error_d = timeout;
    push         = 1'b0;
    new_word     = {partial_q, rx_data};
    if (rx_valid) begin
      unique case (state_q)
        B0: begin
          if (rx_data >= 8'hFC) begin
            cmd_byte_d  = rx_data;
            cmd_valid_d = 1'b1;
          end else begin
            partial_d[23:16] = rx_data;
            state_d          = B1;
          end
        end
        B1: begin
          partial_d[15:8] = rx_data;
          state_d         = B2;
        end
        B2: begin
          partial_d[7:0] = rx_data;
          state_d        = B3;
        end
        B3: begin
          push    = 1'b1;
          state_d = B0;
        end
      endcase
    end else if (timeout) begin
      partial_d = '0;
      state_d   = B0;
    end
  end

  // Two-entry buffer: ent0 is always the head, ent1 the tail.
  always_comb begin
    pop        = (occ_q != 2'd0) && evt_word_ready;
    accept     = push && ((occ_q != 2'd2) || pop);
    occ_popped = occ_q - {1'b0, pop};
    ent0_d     = pop ? ent1_q : ent0_q;
    ent1_d     = ent1_q;
    if (accept) begin
      if (occ_popped == 2'd0) begin
        ent0_d = new_word;
      end else begin
        ent1_d = new_word;
      end
    end
    occ_d  = occ_popped + {1'b0, accept};
    drop_d = drop_q;
    if (push && !accept && (drop_q != {DROP_CNT_W{1'b1}})) begin
      drop_d = drop_q + DROP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= B0;
      partial_q    <= '0;
      ent0_q       <= '0;
      ent1_q       <= '0;
      occ_q        <= 2'd0;
      cmd_byte_q   <= '0;
      cmd_valid_q  <= 1'b0;
      drop_q       <= '0;
      sync_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      partial_q    <= partial_d;
      ent0_q       <= ent0_d;
      ent1_q       <= ent1_d;
      occ_q        <= occ_d;
      cmd_byte_q   <= cmd_byte_d;
      cmd_valid_q  <= cmd_valid_d;
      drop_q       <= drop_d;
      sync_error_q <= sync_error_d;
    end
  end

  assign evt_word       = ent0_q;
  assign evt_word_valid = (occ_q != 2'd0);
  assign cmd_byte       = cmd_byte_q;
  assign cmd_valid      = cmd_valid_q;
  assign drop_count     = drop_q;
  assign sync_error     = sync_error_q;
  assign asm_state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_evt2_word_assembler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_evt2_word_assembler
// Purpose : Directed plus randomized bench for evt2_word_assembler against a
//           queue-based reference model; honours EVT2_ASM_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_evt2_word_assembler;

  localparam int CLK_FREQ      = 12_000_000;
  localparam int BAUD_RATE     = 115200;
  localparam int TIMEOUT_BYTES = 4;
  localparam int DROP_CNT_W    = 8;
  localparam int TMO           = TIMEOUT_BYTES * 10 * (CLK_FREQ / BAUD_RATE);
  localparam int DROP_MAX      = (1 << DROP_CNT_W) - 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic [31:0]           evt_word;
  logic                  evt_word_valid;
  logic                  evt_word_ready;
  logic [7:0]            cmd_byte;
  logic                  cmd_valid;
  logic [DROP_CNT_W-1:0] drop_count;
  logic                  sync_error;
  logic [1:0]            asm_state;

  always #5 clk = ~clk;

  evt2_word_assembler #(
    .CLK_FREQ     (CLK_FREQ),
    .BAUD_RATE    (BAUD_RATE),
    .TIMEOUT_BYTES(TIMEOUT_BYTES),
    .DROP_CNT_W   (DROP_CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .evt_word      (evt_word),
    .evt_word_valid(evt_word_valid),
    .evt_word_ready(evt_word_ready),
    .cmd_byte      (cmd_byte),
    .cmd_valid     (cmd_valid),
    .drop_count    (drop_count),
    .sync_error    (sync_error),
    .asm_state     (asm_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: byte list for the word in progress, FIFO as a queue.
  logic [31:0] m_fifo[$];
  logic [7:0]  m_bytes[4];
  int          m_idx;
  logic [7:0]  m_cmd;
  bit          m_cmd_v;
  int          m_drop;
  bit          m_sync;
  int          m_idle;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_idx   = 0;
    m_cmd   = 8'h00;
    m_cmd_v = 1'b0;
    m_drop  = 0;
    m_sync  = 1'b0;
    m_idle  = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit rdy);
    bit          pop;
    bit          have_word;
    logic [31:0] w;
    pop       = (m_fifo.size() != 0) && rdy;
    have_word = 1'b0;
    w         = 32'h0;
    m_cmd_v   = 1'b0;
    m_sync    = 1'b0;
    if (v) begin
      m_idle = 0;
      if (m_idx == 0 && d >= 8'hFC) begin
        m_cmd   = d;
        m_cmd_v = 1'b1;
      end else begin
        m_bytes[m_idx] = d;
        m_idx++;
        if (m_idx == 4) begin
          w         = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
          have_word = 1'b1;
          m_idx     = 0;
        end
      end
    end else if (m_idx != 0) begin
`ifdef EVT2_ASM_TIMEOUT_EN
      m_idle++;
      if (m_idle == TMO) begin
        m_idx  = 0;
        m_idle = 0;
        m_sync = 1'b1;
      end
`endif
    end
    if (pop) void'(m_fifo.pop_front());
    if (have_word) begin
      if (m_fifo.size() < 2) m_fifo.push_back(w);
      else if (m_drop < DROP_MAX) m_drop++;
    end
  endtask

  task automatic compare_all();
    check("valid", 32'(evt_word_valid), 32'(m_fifo.size() != 0));
    if (m_fifo.size() != 0) check("word", evt_word, m_fifo[0]);
    check("cmd_valid", 32'(cmd_valid), 32'(m_cmd_v));
    check("cmd_byte", 32'(cmd_byte), 32'(m_cmd));
    check("drop", 32'(drop_count), 32'(m_drop));
    check("sync", 32'(sync_error), 32'(m_sync));
    check("state", 32'(asm_state), 32'(m_idx));
  endtask

  // Called at a negedge: drive, predict, cross the posedge, compare.
  task automatic cycle(input bit v, input logic [7:0] d, input bit rdy);
    rx_valid       = v;
    rx_data        = d;
    evt_word_ready = rdy;
    model_step(v, d, rdy);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic send_word(input logic [31:0] w, input bit rdy);
    for (int i = 3; i >= 0; i--) cycle(1'b1, w[8*i +: 8], rdy);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_word"}, evt_word, 32'h0);
    check({tag, "_valid"}, 32'(evt_word_valid), 32'h0);
    check({tag, "_cmd"}, 32'(cmd_byte), 32'h0);
    check({tag, "_cmdv"}, 32'(cmd_valid), 32'h0);
    check({tag, "_drop"}, 32'(drop_count), 32'h0);
    check({tag, "_sync"}, 32'(sync_error), 32'h0);
    check({tag, "_state"}, 32'(asm_state), 32'h0);
  endtask

  initial begin
    int  seen_at;
    bit  v;
    bit  rdy;
    logic [7:0] d;

    rst            = 1'b1;
    rx_valid       = 1'b0;
    rx_data        = 8'h00;
    evt_word_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;

    // Basic word, one-cycle valid with ready high
    send_word(32'h12345678, 1'b1);
    check("t1_word", evt_word, 32'h12345678);
    check("t1_valid", 32'(evt_word_valid), 32'h1);
    cycle(1'b0, 8'h00, 1'b1);
    check("t1_valid_gone", 32'(evt_word_valid), 32'h0);
    check("t1_drop", 32'(drop_count), 32'h0);

    // Command byte in B0, then 0xFF as data in B1
    cycle(1'b1, 8'hFE, 1'b1);
    check("t2_cmdv", 32'(cmd_valid), 32'h1);
    check("t2_cmd", 32'(cmd_byte), 32'hFE);
    send_word(32'h12FF5678, 1'b1);
    check("t2_cmdv_once", 32'(cmd_valid), 32'h0);
    check("t2_word", evt_word, 32'h12FF5678);
    cycle(1'b0, 8'h00, 1'b1);

    // Full buffer: third word dropped
    send_word(32'hA1A2A3A4, 1'b0);
    send_word(32'hB1B2B3B4, 1'b0);
    send_word(32'hC1C2C3C4, 1'b0);
    check("t3_head", evt_word, 32'hA1A2A3A4);
    check("t3_drop", 32'(drop_count), 32'h1);
    cycle(1'b0, 8'h00, 1'b1);
    check("t3_second", evt_word, 32'hB1B2B3B4);
    cycle(1'b0, 8'h00, 1'b1);
    check("t3_empty", 32'(evt_word_valid), 32'h0);

    // Push coincident with pop at occupancy 2
    send_word(32'h0A0B0C0D, 1'b0);
    send_word(32'h1A1B1C1D, 1'b0);
    cycle(1'b1, 8'h2A, 1'b0);
    cycle(1'b1, 8'h2B, 1'b0);
    cycle(1'b1, 8'h2C, 1'b0);
    cycle(1'b1, 8'h2D, 1'b1);
    check("t4_head", evt_word, 32'h1A1B1C1D);
    check("t4_drop", 32'(drop_count), 32'h1);
    cycle(1'b0, 8'h00, 1'b1);
    check("t4_tail", evt_word, 32'h2A2B2C2D);
    cycle(1'b0, 8'h00, 1'b1);
    check("t4_empty", 32'(evt_word_valid), 32'h0);

    // Silence after a partial word
    cycle(1'b1, 8'hAA, 1'b1);
    cycle(1'b1, 8'hBB, 1'b1);
    seen_at = 0;
    for (int i = 1; i <= TMO + 8; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      if (sync_error && seen_at == 0) begin
        seen_at = i;
        check("t5_state_at_sync", 32'(asm_state), 32'h0);
      end
    end
`ifdef EVT2_ASM_TIMEOUT_EN
    check("t5_sync_delay", 32'(seen_at), 32'(TMO));
    send_word(32'h01020304, 1'b1);
    check("t5_word", evt_word, 32'h01020304);
`else
    check("t5_no_sync", 32'(seen_at), 32'h0);
    cycle(1'b1, 8'h01, 1'b1);
    cycle(1'b1, 8'h02, 1'b1);
    check("t5_word", evt_word, 32'hAABB0102);
`endif
    cycle(1'b0, 8'h00, 1'b1);

    // Asynchronous reset with a word buffered and a partial in flight
    send_word(32'hDEADBEEF, 1'b0);
    cycle(1'b1, 8'h11, 1'b0);
    cycle(1'b1, 8'h22, 1'b0);
    #2 rst = 1'b1;
    #1 check_zero_outputs("arst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    compare_all();
    send_word(32'h31323334, 1'b1);
    check("t6_word", evt_word, 32'h31323334);
    check("t6_drop", 32'(drop_count), 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      v   = ($urandom_range(0, 2) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      d   = ($urandom_range(0, 3) == 0) ? 8'(8'hFC + $urandom_range(0, 3))
                                        : 8'($urandom_range(0, 255));
      cycle(v, d, rdy);
    end

    // Drop counter saturation
    for (int i = 0; i < DROP_MAX + 6; i++) send_word($urandom, 1'b0);
    check("t7_drop_sat", 32'(drop_count), 32'(DROP_MAX));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
